// File: rtl/bp_clint_ctrl.sv
// Core-local interruptor: per-hart msip/mtimecmp, shared mtime, one-deep request/response port.
// Define BP_CLINT_PRESCALER_EN to advance mtime once every rtc_div_p clocks instead of every clock.
`timescale 1ns/1ps
module bp_clint_ctrl #(
    parameter int num_core_p    = 1,
    parameter int paddr_width_p = 56,
    parameter int rtc_div_p     = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic                     req_w_i,
    input  logic [paddr_width_p-1:0] req_addr_i,
    input  logic [63:0]              req_data_i,
    input  logic [7:0]               req_mask_i,
    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic [63:0]              resp_data_o,
    output logic                     resp_err_o,
    output logic [num_core_p-1:0]    timer_irq_o,
    output logic [num_core_p-1:0]    soft_irq_o
);

    localparam logic [63:0] msip_base     = 64'h0000_0000_0200_0000;
    localparam logic [63:0] mtimecmp_base = 64'h0000_0000_0200_4000;
    localparam logic [63:0] mtime_addr    = 64'h0000_0000_0200_bff8;

    typedef enum logic {e_idle, e_resp} state_e;

    state_e                state_q;
    logic [63:0]           mtime_q;
    logic [63:0]           mtimecmp_q [num_core_p];
    logic [num_core_p-1:0] msip_q;
    logic [num_core_p-1:0] timer_irq_q;
    logic [63:0]           resp_data_q;
    logic                  resp_err_q;

    logic                  accept;
    logic                  wr_en;
    logic                  tick;
    logic [63:0]           addr_ext;
    logic                  hit_mtime;
    logic                  hit_any;
    logic [num_core_p-1:0] hit_msip;
    logic [num_core_p-1:0] hit_cmp;
    logic [63:0]           rd_data;

    function automatic logic [63:0] apply_mask(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  mask);
        logic [63:0] r;
        r = old_val;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

    // Zero-extending before the compare makes any set bit above 31 a miss.
    assign addr_ext = 64'(req_addr_i);
    assign accept   = req_v_i & (state_q == e_idle);
    assign wr_en    = accept & req_w_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        hit_msip  = '0;
        hit_cmp   = '0;
        rd_data   = '0;
        hit_mtime = (addr_ext == mtime_addr);
        if (hit_mtime) rd_data = mtime_q;
        for (int i = 0; i < num_core_p; i++) begin
            hit_msip[i] = (addr_ext == msip_base + 64'(4 * i));
            hit_cmp[i]  = (addr_ext == mtimecmp_base + 64'(8 * i));
            if (hit_msip[i]) rd_data = {63'd0, msip_q[i]};
            if (hit_cmp[i])  rd_data = mtimecmp_q[i];
        end
    end

    assign hit_any = hit_mtime | (|hit_msip) | (|hit_cmp);

`ifdef BP_CLINT_PRESCALER_EN
    localparam int pre_w = (rtc_div_p > 1) ? $clog2(rtc_div_p) : 1;

    logic [pre_w-1:0] prescale_q;

    assign tick = (prescale_q == pre_w'(rtc_div_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) prescale_q <= '0;
        else            prescale_q <= tick ? '0 : prescale_q + pre_w'(1);
    end
`else
    localparam int unused_rtc_div = rtc_div_p;

    assign tick = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_idle;
            mtime_q     <= '0;
            msip_q      <= '0;
            timer_irq_q <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            // NOTE: the mtimecmp array is a handful of flops, not a RAM, so it takes the async reset.
            for (int i = 0; i < num_core_p; i++) mtimecmp_q[i] <= '1;
        end else begin
            // NOTE: state is written with <= only, so every read below sees the pre-edge value.
            case (state_q)
                e_idle: if (req_v_i) begin
                    state_q     <= e_resp;
                    resp_data_q <= req_w_i ? 64'd0 : rd_data;
                    resp_err_q  <= ~hit_any;
                end
                e_resp: if (resp_yumi_i) state_q <= e_idle;
            endcase

            // A software write to mtime overrides a tick landing on the same edge.
            if (wr_en && hit_mtime) mtime_q <= apply_mask(mtime_q, req_data_i, req_mask_i);
            else if (tick)          mtime_q <= mtime_q + 64'd1;

            for (int i = 0; i < num_core_p; i++) begin
                if (wr_en && hit_msip[i] && req_mask_i[0]) msip_q[i] <= req_data_i[0];
                if (wr_en && hit_cmp[i]) mtimecmp_q[i] <= apply_mask(mtimecmp_q[i], req_data_i, req_mask_i);
                timer_irq_q[i] <= (mtime_q >= mtimecmp_q[i]);
            end
        end
    end

    assign req_ready_o = (state_q == e_idle);
    assign resp_v_o    = (state_q == e_resp);
    assign resp_data_o = resp_data_q;
    assign resp_err_o  = resp_err_q;
    assign timer_irq_o = timer_irq_q;
    assign soft_irq_o  = msip_q;

endmodule
